// File: rtl/dmem_responder_if.sv
// ============================================================================
//  Module      : dmem_responder_if
//  Description : MEMORY-stage request/response bundle between core and dmem.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if #(
  parameter int SB_DEPTH = 4
);
  localparam int CW = $clog2(SB_DEPTH) + 1;

  logic [31:0]   addrM;
  logic [31:0]   writedataM;
  logic          memwriteM;
  logic          memreadM;
  logic [2:0]    memsizeM;
  logic [31:0]   readdataM;
  logic          misalignM;
  logic [CW-1:0] sb_count;

  modport master (
    output addrM, writedataM, memwriteM, memreadM, memsizeM,
    input  readdataM, misalignM, sb_count
  );

  modport slave (
    input  addrM, writedataM, memwriteM, memreadM, memsizeM,
    output readdataM, misalignM, sb_count
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-port data memory with posted in-order store buffer and
//                store-to-load byte forwarding; combinational load data.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int WORDS    = 4096,
  parameter int SB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int IW = $clog2(WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem     [WORDS];
  logic [IW-1:0] sb_idx  [SB_DEPTH];
  logic [3:0]    sb_be   [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          misalign;

  logic [1:0]    off;
  logic [IW-1:0] idx;
  logic          size_ok;
  logic          misal;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic          do_enq;
  logic          do_drain;
  logic [31:0]   merged;
  logic [31:0]   lane;
  logic [31:0]   rdata;
  logic [PW-1:0] slot;

  // Request decode: legality, byte enables and lane-shifted store data
  always_comb begin
    off        = bus.addrM[1:0];
    idx        = bus.addrM[IW+1:2];
    size_ok    = 1'b0;
    misal      = 1'b0;
    be         = 4'b1111;
    wdata_lane = bus.writedataM << {off, 3'b000};
    case (bus.memsizeM)
      3'b000, 3'b100: size_ok = 1'b1;
      3'b001, 3'b101: begin size_ok = 1'b1; misal = off[0]; end
      3'b010:         begin size_ok = 1'b1; misal = |off;   end
      default:        size_ok = 1'b0;
    endcase
    case (bus.memsizeM[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    bad      = (bus.memreadM | bus.memwriteM) & (~size_ok | misal);
    do_enq   = bus.memwriteM & ~bad;
    do_drain = ~bus.memreadM & (count != '0);
  end

  // Walk oldest to youngest so the youngest matching store owns each byte
  always_comb begin
    merged = mem[idx];
    slot   = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot = head + PW'(k);
      if ((CW'(k) < count) && (sb_idx[slot] == idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_be[slot][b]) merged[8*b +: 8] = sb_data[slot][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    lane  = merged >> {off, 3'b000};
    rdata = '0;
    case (bus.memsizeM)
      3'b000:  rdata = {{24{lane[7]}},  lane[7:0]};
      3'b001:  rdata = {{16{lane[15]}}, lane[15:0]};
      3'b010:  rdata = merged;
      3'b100:  rdata = {24'd0, lane[7:0]};
      3'b101:  rdata = {16'd0, lane[15:0]};
      default: rdata = '0;
    endcase
    if (!bus.memreadM || bad) rdata = '0;
  end

  assign bus.readdataM = rdata;
  assign bus.misalignM = misalign;
  assign bus.sb_count  = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      if (bad)      misalign <= 1'b1;
      if (do_drain) head     <= head + PW'(1);
      if (do_enq)   tail     <= tail + PW'(1);
      case ({do_enq, do_drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_drain) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_be[head][b]) mem[sb_idx[head]][8*b +: 8] <= sb_data[head][8*b +: 8];
        end
      end
      if (do_enq) begin
        sb_idx[tail]  <= idx;
        sb_be[tail]   <= be;
        sb_data[tail] <= wdata_lane;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Randomized scoreboard bench for dmem_responder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;
  localparam int WORDS    = 4096;
  localparam int SB_DEPTH = 4;
  localparam int SPAN     = WORDS * 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.SB_DEPTH(SB_DEPTH)) bus ();

  dmem_responder #(.WORDS(WORDS), .SB_DEPTH(SB_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd;
    int          cnt;
    logic        mis;
    int          cyc;
  } exp_t;

  typedef struct {
    int          base;
    logic [3:0]  be;
    logic [31:0] data;
  } st_t;

  exp_t       expq [$];
  st_t        pend [$];
  logic [7:0] mmem [int];
  logic       mis_m = 1'b0;
  int         cyc   = 0;
  int         tests = 0;
  int         fails = 0;

  // Architectural byte value: committed memory overlaid by pending stores in order
  function automatic logic [7:0] peek(input int a);
    logic [7:0] v;
    v = mmem.exists(a) ? mmem[a] : 8'h00;
    foreach (pend[i]) begin
      if (pend[i].base == (a - (a % 4)) && pend[i].be[a % 4])
        v = pend[i].data[8*(a % 4) +: 8];
    end
    return v;
  endfunction

  task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size);
    int          a;
    int          nb;
    bit          sgn;
    bit          ill;
    bit          bad;
    logic [31:0] v;
    exp_t        e;
    st_t         s;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.memreadM   = rd;
    bus.memwriteM  = wr;
    bus.addrM      = addr;
    bus.writedataM = wdata;
    bus.memsizeM   = size;
    a   = int'(addr % SPAN);
    sgn = 1'b0;
    ill = 1'b0;
    case (size)
      3'd0:    begin nb = 1; sgn = 1'b1; end
      3'd1:    begin nb = 2; sgn = 1'b1; end
      3'd2:    nb = 4;
      3'd4:    nb = 1;
      3'd5:    nb = 2;
      default: begin nb = 1; ill = 1'b1; end
    endcase
    bad = (rd || wr) && (ill || (a % nb) != 0);
    v = '0;
    if (rd && !bad) begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = peek(a + i);
      if (sgn) for (int i = 0; i < 32; i++) if (i >= 8*nb) v[i] = v[8*nb-1];
    end
    e.rd  = v;
    e.cnt = pend.size();
    e.mis = mis_m;
    e.cyc = cyc;
    expq.push_back(e);
    cyc++;
    if (bad) mis_m = 1'b1;
    if (!rd && pend.size() > 0) begin
      s = pend.pop_front();
      for (int b = 0; b < 4; b++) if (s.be[b]) mmem[s.base + b] = s.data[8*b +: 8];
    end
    if (wr && !bad) begin
      s.base = a - (a % 4);
      s.be   = '0;
      s.data = '0;
      for (int i = 0; i < nb; i++) begin
        s.be[(a % 4) + i]             = 1'b1;
        s.data[8*((a % 4) + i) +: 8]  = wdata[8*i +: 8];
      end
      pend.push_back(s);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    bus.memreadM   = 1'b0;
    bus.memwriteM  = 1'b0;
    bus.addrM      = '0;
    bus.writedataM = '0;
    bus.memsizeM   = '0;
    pend.delete();
    mis_m = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      tests += 3;
      if (bus.readdataM !== e.rd) begin
        fails++;
        $display("FAIL readdata cyc=%0d got=%h exp=%h", e.cyc, bus.readdataM, e.rd);
      end
      if (int'(bus.sb_count) != e.cnt || $isunknown(bus.sb_count)) begin
        fails++;
        $display("FAIL sb_count cyc=%0d got=%0d exp=%0d", e.cyc, bus.sb_count, e.cnt);
      end
      if (bus.misalignM !== e.mis) begin
        fails++;
        $display("FAIL misalign cyc=%0d got=%b exp=%b", e.cyc, bus.misalignM, e.mis);
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [2:0]  rs;
    int          op;
    bus.memreadM   = 1'b0;
    bus.memwriteM  = 1'b0;
    bus.addrM      = '0;
    bus.writedataM = '0;
    bus.memsizeM   = '0;

    // Give every word the bench reads a known value
    for (int w = 0; w < 256; w++) step(0, 1, 32'(w * 4), $urandom, 3'd2);
    step(0, 0, 0, 0, 0);

    step(0, 1, 32'h100, 32'hDEADBEEF, 3'd2);
    step(0, 0, 0, 0, 0);
    step(1, 0, 32'h100, 0, 3'd2);

    step(0, 1, 32'h203, 32'h80, 3'd0);
    step(1, 0, 32'h203, 0, 3'd0);
    step(1, 0, 32'h203, 0, 3'd4);

    step(0, 1, 32'h40, 32'h11223344, 3'd2);
    step(0, 1, 32'h42, 32'h0000AABB, 3'd1);
    step(1, 0, 32'h40, 0, 3'd2);

    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'(i * 4), 0, 3'd2);
      step(0, 1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 3'd2);
    end
    step(0, 1, 32'h10, 32'hC0DE0004, 3'd2);
    for (int i = 0; i < 5; i++) step(1, 0, 32'(i * 4), 0, 3'd2);

    step(1, 0, 32'h101, 0, 3'd1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h102, 32'h12345678, 3'd2);
    step(1, 0, 32'h100, 0, 3'd2);

    step(0, 1, 32'h0, 32'h5, 3'd2);
    do_reset();
    step(1, 0, 32'h0, 0, 3'd2);
    step(1, 0, 32'h0, 0, 3'd2);

    for (int n = 0; n < 800; n++) begin
      op = int'($urandom_range(0, 99));
      ra = $urandom & 32'hFFFF_C3FF;
      case ($urandom_range(0, 9))
        0, 1:    rs = 3'd0;
        2, 3:    rs = 3'd1;
        4, 5:    rs = 3'd2;
        6:       rs = 3'd4;
        7, 8:    rs = 3'd5;
        default: rs = 3'($urandom_range(3, 7));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (rs[1:0] == 2'b01) ra[0]   = 1'b0;
        if (rs == 3'd2)       ra[1:0] = 2'b00;
      end
      if (op < 2)       do_reset();
      else if (op < 20) step(0, 0, ra, $urandom, rs);
      else if (op < 60) step(1, 0, ra, $urandom, rs);
      else              step(0, 1, ra, $urandom, rs);
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
